// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: registers a control bundle for EX with
// valid/ready handshakes, a one-bubble load-use interlock, flush and an
// illegal-instruction halt.
module decode_stage #(
   parameter int XLEN       = 32,
   parameter int REG_BITS   = 5,
   parameter int ALUOP_BITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_instr,
   input  logic [XLEN-1:0]       in_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_pc,
   output logic [REG_BITS-1:0]   out_rs1,
   output logic [REG_BITS-1:0]   out_rs2,
   output logic [REG_BITS-1:0]   out_rd,
   output logic [XLEN-1:0]       out_imm,
   output logic [ALUOP_BITS-1:0] out_alu_op,
   output logic                  out_src_a_pc,
   output logic                  out_src_b_imm,
   output logic                  out_reg_write,
   output logic                  out_mem_read,
   output logic                  out_mem_write,
   output logic [2:0]            out_mem_size,
   output logic                  out_branch,
   output logic                  out_jump,
   output logic                  out_illegal
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [ALUOP_BITS-1:0] ALU_ADD   = ALUOP_BITS'(0);
   localparam logic [ALUOP_BITS-1:0] ALU_SUB   = ALUOP_BITS'(1);
   localparam logic [ALUOP_BITS-1:0] ALU_SLL   = ALUOP_BITS'(2);
   localparam logic [ALUOP_BITS-1:0] ALU_SLT   = ALUOP_BITS'(3);
   localparam logic [ALUOP_BITS-1:0] ALU_SLTU  = ALUOP_BITS'(4);
   localparam logic [ALUOP_BITS-1:0] ALU_XOR   = ALUOP_BITS'(5);
   localparam logic [ALUOP_BITS-1:0] ALU_SRL   = ALUOP_BITS'(6);
   localparam logic [ALUOP_BITS-1:0] ALU_SRA   = ALUOP_BITS'(7);
   localparam logic [ALUOP_BITS-1:0] ALU_OR    = ALUOP_BITS'(8);
   localparam logic [ALUOP_BITS-1:0] ALU_AND   = ALUOP_BITS'(9);
   localparam logic [ALUOP_BITS-1:0] ALU_EQ    = ALUOP_BITS'(10);
   localparam logic [ALUOP_BITS-1:0] ALU_NE    = ALUOP_BITS'(11);
   localparam logic [ALUOP_BITS-1:0] ALU_GE    = ALUOP_BITS'(12);
   localparam logic [ALUOP_BITS-1:0] ALU_GEU   = ALUOP_BITS'(13);
   localparam logic [ALUOP_BITS-1:0] ALU_PASSB = ALUOP_BITS'(14);

   localparam logic [1:0] RUN    = 2'd0;
   localparam logic [1:0] BUBBLE = 2'd1;
   localparam logic [1:0] HALT   = 2'd2;

   // Immediate formats, built at 32 bits with their sign bit in bit 31
   function automatic logic signed [31:0] immI(input logic [31:0] i);
      return {{20{i[31]}}, i[31:20]};
   endfunction
   function automatic logic signed [31:0] immS(input logic [31:0] i);
      return {{20{i[31]}}, i[31:25], i[11:7]};
   endfunction
   function automatic logic signed [31:0] immB(input logic [31:0] i);
      return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
   endfunction
   function automatic logic signed [31:0] immU(input logic [31:0] i);
      return {i[31:12], 12'b0};
   endfunction
   function automatic logic signed [31:0] immJ(input logic [31:0] i);
      return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
   endfunction
   function automatic logic signed [XLEN-1:0] signExtend(input logic signed [31:0] v);
      return XLEN'(v);
   endfunction

   // Arithmetic ops shared by register and immediate forms; alt picks SUB/SRA
   function automatic logic [ALUOP_BITS-1:0] aluArith(input logic [2:0] f3, input logic alt);
      case (f3)
         3'd0:    return alt ? ALU_SUB : ALU_ADD;
         3'd1:    return ALU_SLL;
         3'd2:    return ALU_SLT;
         3'd3:    return ALU_SLTU;
         3'd4:    return ALU_XOR;
         3'd5:    return alt ? ALU_SRA : ALU_SRL;
         3'd6:    return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   logic [6:0]               opcode;
   logic [2:0]               f3;
   logic [REG_BITS-1:0]      decRs1, decRs2, decRd;
   logic signed [XLEN-1:0]   decImm;
   logic [ALUOP_BITS-1:0]    decAluOp;
   logic                     decSrcAPc, decSrcBImm, decWantWrite, decRegWrite;
   logic                     decMemRead, decMemWrite, decBranch, decJump, decIllegal;
   logic [2:0]               decMemSize;

   logic [1:0]               state_p1, curState;
   logic                     vld_p1;
   logic                     loadRdVld_p1;
   logic [REG_BITS-1:0]      loadRd_p1;
   logic                     hazard, accept, handoff;

   assign opcode = in_instr[6:0];
   assign f3     = in_instr[14:12];

   // Stage 0: combinational decode of the offered instruction
   always_comb begin
      decRs1       = '0;
      decRs2       = '0;
      decRd        = '0;
      decImm       = '0;
      decAluOp     = ALU_ADD;
      decSrcAPc    = 1'b0;
      decSrcBImm   = 1'b0;
      decWantWrite = 1'b0;
      decMemRead   = 1'b0;
      decMemWrite  = 1'b0;
      decMemSize   = 3'd0;
      decBranch    = 1'b0;
      decJump      = 1'b0;
      decIllegal   = 1'b0;
      case (opcode)
         OP_REG: begin
            decRs1 = REG_BITS'(in_instr[19:15]);
            decRs2 = REG_BITS'(in_instr[24:20]);
            decRd = REG_BITS'(in_instr[11:7]);
            decWantWrite = 1'b1;
            decAluOp = aluArith(f3, in_instr[30]);
         end
         OP_IMM: begin
            decRs1 = REG_BITS'(in_instr[19:15]);
            decRd = REG_BITS'(in_instr[11:7]);
            decWantWrite = 1'b1;
            decSrcBImm = 1'b1;
            decImm = signExtend(immI(in_instr));
            decAluOp = aluArith(f3, (f3 == 3'd5) && in_instr[30]);
         end
         OP_LOAD: begin
            decRs1 = REG_BITS'(in_instr[19:15]);
            decRd = REG_BITS'(in_instr[11:7]);
            decWantWrite = 1'b1;
            decSrcBImm = 1'b1;
            decMemRead = 1'b1;
            decMemSize = f3;
            decImm = signExtend(immI(in_instr));
         end
         OP_STORE: begin
            decRs1 = REG_BITS'(in_instr[19:15]);
            decRs2 = REG_BITS'(in_instr[24:20]);
            decSrcBImm = 1'b1;
            decMemWrite = 1'b1;
            decMemSize = f3;
            decImm = signExtend(immS(in_instr));
         end
         OP_BRANCH: begin
            if (f3 == 3'd2 || f3 == 3'd3) begin
               decIllegal = 1'b1;
            end else begin
               decRs1 = REG_BITS'(in_instr[19:15]);
               decRs2 = REG_BITS'(in_instr[24:20]);
               decBranch = 1'b1;
               decImm = signExtend(immB(in_instr));
               case (f3)
                  3'd0:    decAluOp = ALU_EQ;
                  3'd1:    decAluOp = ALU_NE;
                  3'd4:    decAluOp = ALU_SLT;
                  3'd5:    decAluOp = ALU_GE;
                  3'd6:    decAluOp = ALU_SLTU;
                  default: decAluOp = ALU_GEU;
               endcase
            end
         end
         OP_JAL: begin
            decRd = REG_BITS'(in_instr[11:7]);
            decWantWrite = 1'b1;
            decJump = 1'b1;
            decSrcAPc = 1'b1;
            decSrcBImm = 1'b1;
            decImm = signExtend(immJ(in_instr));
         end
         OP_JALR: begin
            decRs1 = REG_BITS'(in_instr[19:15]);
            decRd = REG_BITS'(in_instr[11:7]);
            decWantWrite = 1'b1;
            decJump = 1'b1;
            decSrcBImm = 1'b1;
            decImm = signExtend(immI(in_instr));
         end
         OP_LUI: begin
            decRd = REG_BITS'(in_instr[11:7]);
            decWantWrite = 1'b1;
            decSrcBImm = 1'b1;
            decAluOp = ALU_PASSB;
            decImm = signExtend(immU(in_instr));
         end
         OP_AUIPC: begin
            decRd = REG_BITS'(in_instr[11:7]);
            decWantWrite = 1'b1;
            decSrcAPc = 1'b1;
            decSrcBImm = 1'b1;
            decImm = signExtend(immU(in_instr));
         end
         default: decIllegal = 1'b1;
      endcase
      decRegWrite = decWantWrite && (decRd != '0);
   end

   // Unused register fields decode to 0, so a plain compare only sees real reads
   assign hazard   = loadRdVld_p1 && in_valid &&
                     ((decRs1 == loadRd_p1) || (decRs2 == loadRd_p1));
   assign curState = (state_p1 == RUN && hazard) ? BUBBLE : state_p1;
   assign out_valid = vld_p1 && (curState != BUBBLE);
   assign in_ready  = !reset && !flush && (!vld_p1 || out_ready) && (curState == RUN);
   assign accept    = in_valid && in_ready;
   assign handoff   = out_valid && out_ready;

   // Stage 1 control: valid, halt state and the one-cycle load-use window
   always_ff @(posedge clk) begin
      if (reset) begin
         state_p1     <= RUN;
         vld_p1       <= 1'b0;
         loadRdVld_p1 <= 1'b0;
         loadRd_p1    <= '0;
      end else if (flush) begin
         state_p1     <= RUN;
         vld_p1       <= 1'b0;
         loadRdVld_p1 <= 1'b0;
      end else begin
         loadRdVld_p1 <= handoff && out_mem_read && (out_rd != '0);
         loadRd_p1    <= out_rd;
         if (accept) begin
            vld_p1 <= 1'b1;
            if (decIllegal) state_p1 <= HALT;
         end else if (handoff) begin
            vld_p1 <= 1'b0;
         end
      end
   end

   // Stage 1 bundle: captured on accept, otherwise held for EX
   always_ff @(posedge clk) begin
      if (reset) begin
         out_pc        <= '0;
         out_rs1       <= '0;
         out_rs2       <= '0;
         out_rd        <= '0;
         out_imm       <= '0;
         out_alu_op    <= '0;
         out_src_a_pc  <= 1'b0;
         out_src_b_imm <= 1'b0;
         out_reg_write <= 1'b0;
         out_mem_read  <= 1'b0;
         out_mem_write <= 1'b0;
         out_mem_size  <= 3'd0;
         out_branch    <= 1'b0;
         out_jump      <= 1'b0;
         out_illegal   <= 1'b0;
      end else if (accept) begin
         out_pc        <= in_pc;
         out_rs1       <= decRs1;
         out_rs2       <= decRs2;
         out_rd        <= decRd;
         out_imm       <= decImm;
         out_alu_op    <= decAluOp;
         out_src_a_pc  <= decSrcAPc;
         out_src_b_imm <= decSrcBImm;
         out_reg_write <= decRegWrite;
         out_mem_read  <= decMemRead;
         out_mem_write <= decMemWrite;
         out_mem_size  <= decMemSize;
         out_branch    <= decBranch;
         out_jump      <= decJump;
         out_illegal   <= decIllegal;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a 32-bit and a 64-bit instance share stimulus.
module tb_decode_stage;

   localparam logic [31:0] ADDI    = 32'h00500093; // addi x1,x0,5
   localparam logic [31:0] SUB     = 32'h402081B3; // sub x3,x1,x2
   localparam logic [31:0] LW      = 32'h0000A283; // lw x5,0(x1)
   localparam logic [31:0] ADD_DEP = 32'h00128333; // add x6,x5,x1
   localparam logic [31:0] ADD_IND = 32'h00208333; // add x6,x1,x2
   localparam logic [31:0] BEQ     = 32'hFE208CE3; // beq x1,x2,-8
   localparam logic [31:0] BADBR   = 32'hFE20ACE3; // branch with func3=2
   localparam logic [31:0] LUI     = 32'h800003B7; // lui x7,0x80000

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, flush, inValid, outReady;
   logic [31:0] inInstr, inPc;
   logic [63:0] inPc64;
   assign inPc64 = {32'h0, inPc};

   logic inReady, outValid, outSrcAPc, outSrcBImm, outRegWrite, outMemRead, outMemWrite;
   logic outBranch, outJump, outIllegal;
   logic [31:0] outPc, outImm;
   logic [4:0] outRs1, outRs2, outRd;
   logic [3:0] outAluOp;
   logic [2:0] outMemSize;

   logic inReady64, outValid64, outSrcAPc64, outSrcBImm64, outRegWrite64, outMemRead64;
   logic outMemWrite64, outBranch64, outJump64, outIllegal64;
   logic [63:0] outPc64, outImm64;
   logic [4:0] outRs164, outRs264, outRd64;
   logic [3:0] outAluOp64;
   logic [2:0] outMemSize64;

   decode_stage #(.XLEN(32), .REG_BITS(5), .ALUOP_BITS(4)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(inValid), .in_ready(inReady), .in_instr(inInstr), .in_pc(inPc),
      .out_valid(outValid), .out_ready(outReady), .out_pc(outPc),
      .out_rs1(outRs1), .out_rs2(outRs2), .out_rd(outRd), .out_imm(outImm),
      .out_alu_op(outAluOp), .out_src_a_pc(outSrcAPc), .out_src_b_imm(outSrcBImm),
      .out_reg_write(outRegWrite), .out_mem_read(outMemRead), .out_mem_write(outMemWrite),
      .out_mem_size(outMemSize), .out_branch(outBranch), .out_jump(outJump),
      .out_illegal(outIllegal)
   );

   decode_stage #(.XLEN(64), .REG_BITS(5), .ALUOP_BITS(4)) dut64 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(inValid), .in_ready(inReady64), .in_instr(inInstr), .in_pc(inPc64),
      .out_valid(outValid64), .out_ready(outReady), .out_pc(outPc64),
      .out_rs1(outRs164), .out_rs2(outRs264), .out_rd(outRd64), .out_imm(outImm64),
      .out_alu_op(outAluOp64), .out_src_a_pc(outSrcAPc64), .out_src_b_imm(outSrcBImm64),
      .out_reg_write(outRegWrite64), .out_mem_read(outMemRead64), .out_mem_write(outMemWrite64),
      .out_mem_size(outMemSize64), .out_branch(outBranch64), .out_jump(outJump64),
      .out_illegal(outIllegal64)
   );

   int testCount = 0;
   int failCount = 0;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
      inValid = 1'b1;
      inInstr = instr;
      inPc    = pc;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; inValid = 1'b0; inInstr = '0; inPc = '0; outReady = 1'b0;
      tick(); tick();
      settle();
      checkVal("rst_out_valid", 64'(outValid), 64'd0);
      checkVal("rst_in_ready", 64'(inReady), 64'd0);
      checkVal("rst_imm", 64'(outImm), 64'd0);
      checkVal("rst_rd", 64'(outRd), 64'd0);
      tick();
      reset = 1'b0; outReady = 1'b1;

      // addi x1,x0,5
      offer(ADDI, 32'h0);
      settle();
      checkVal("t1_in_ready", 64'(inReady), 64'd1);
      tick();
      inValid = 1'b0;
      settle();
      checkVal("t1_valid", 64'(outValid), 64'd1);
      checkVal("t1_alu_op", 64'(outAluOp), 64'd0);
      checkVal("t1_rd", 64'(outRd), 64'd1);
      checkVal("t1_rs1", 64'(outRs1), 64'd0);
      checkVal("t1_imm", 64'(outImm), 64'd5);
      checkVal("t1_src_b_imm", 64'(outSrcBImm), 64'd1);
      checkVal("t1_reg_write", 64'(outRegWrite), 64'd1);
      tick();
      settle();
      checkVal("t1_drained", 64'(outValid), 64'd0);

      // sub held by out_ready=0 for three cycles
      tick();
      outReady = 1'b0;
      offer(SUB, 32'h4);
      tick();
      offer(ADDI, 32'h8);
      for (int i = 0; i < 3; i++) begin
         settle();
         checkVal("t2_hold_valid", 64'(outValid), 64'd1);
         checkVal("t2_hold_alu_op", 64'(outAluOp), 64'd1);
         checkVal("t2_hold_pc", 64'(outPc), 64'h4);
         checkVal("t2_hold_rd", 64'(outRd), 64'd3);
         checkVal("t2_hold_in_ready", 64'(inReady), 64'd0);
         tick();
      end
      outReady = 1'b1;
      settle();
      checkVal("t2_rs2", 64'(outRs2), 64'd2);
      checkVal("t2_release_in_ready", 64'(inReady), 64'd1);
      tick();
      inValid = 1'b0;
      settle();
      checkVal("t2_next_pc", 64'(outPc), 64'h8);
      checkVal("t2_next_alu_op", 64'(outAluOp), 64'd0);
      tick();

      // lw x5 then dependent add: one bubble
      offer(LW, 32'h10);
      tick();
      inValid = 1'b0;
      settle();
      checkVal("t3_lw_mem_read", 64'(outMemRead), 64'd1);
      checkVal("t3_lw_rd", 64'(outRd), 64'd5);
      checkVal("t3_lw_size", 64'(outMemSize), 64'd2);
      checkVal("t3_lw_alu_op", 64'(outAluOp), 64'd0);
      tick();
      offer(ADD_DEP, 32'h14);
      settle();
      checkVal("t3_bubble_in_ready", 64'(inReady), 64'd0);
      checkVal("t3_bubble_out_valid", 64'(outValid), 64'd0);
      tick();
      settle();
      checkVal("t3_after_bubble_in_ready", 64'(inReady), 64'd1);
      tick();
      inValid = 1'b0;
      settle();
      checkVal("t3_add_valid", 64'(outValid), 64'd1);
      checkVal("t3_add_rs1", 64'(outRs1), 64'd5);
      checkVal("t3_add_rs2", 64'(outRs2), 64'd1);
      checkVal("t3_add_pc", 64'(outPc), 64'h14);
      tick();

      // lw x5 then independent add: no bubble
      offer(LW, 32'h18);
      tick();
      inValid = 1'b0;
      tick();
      offer(ADD_IND, 32'h1C);
      settle();
      checkVal("t3_nodep_in_ready", 64'(inReady), 64'd1);
      tick();
      inValid = 1'b0;
      settle();
      checkVal("t3_nodep_pc", 64'(outPc), 64'h1C);
      checkVal("t3_nodep_rs2", 64'(outRs2), 64'd2);
      tick();

      // beq x1,x2,-8
      offer(BEQ, 32'h20);
      tick();
      inValid = 1'b0;
      settle();
      checkVal("t4_beq_alu_op", 64'(outAluOp), 64'd10);
      checkVal("t4_beq_branch", 64'(outBranch), 64'd1);
      checkVal("t4_beq_imm", 64'(outImm), 64'hFFFFFFF8);
      checkVal("t4_beq_reg_write", 64'(outRegWrite), 64'd0);
      checkVal("t4_beq_jump", 64'(outJump), 64'd0);
      checkVal("t4_beq_mem_write", 64'(outMemWrite), 64'd0);
      checkVal("t4_beq_src_a_pc", 64'(outSrcAPc), 64'd0);
      tick();

      // illegal branch func3, then HALT until flush
      offer(BADBR, 32'h24);
      tick();
      offer(ADDI, 32'h28);
      settle();
      checkVal("t4_ill_valid", 64'(outValid), 64'd1);
      checkVal("t4_ill_flag", 64'(outIllegal), 64'd1);
      checkVal("t4_ill_branch", 64'(outBranch), 64'd0);
      checkVal("t4_ill_reg_write", 64'(outRegWrite), 64'd0);
      checkVal("t4_ill_in_ready", 64'(inReady), 64'd0);
      tick();
      settle();
      checkVal("t4_halt_valid", 64'(outValid), 64'd0);
      checkVal("t4_halt_in_ready", 64'(inReady), 64'd0);
      tick();
      settle();
      checkVal("t4_halt_in_ready_2", 64'(inReady), 64'd0);
      tick();
      flush = 1'b1;
      settle();
      checkVal("t4_flush_in_ready", 64'(inReady), 64'd0);
      tick();
      flush = 1'b0;
      settle();
      checkVal("t4_resume_in_ready", 64'(inReady), 64'd1);
      tick();
      inValid = 1'b0;
      settle();
      checkVal("t4_resume_valid", 64'(outValid), 64'd1);
      checkVal("t4_resume_pc", 64'(outPc), 64'h28);
      checkVal("t4_resume_illegal", 64'(outIllegal), 64'd0);
      tick();

      // flush while a bundle is held and an instruction is offered
      outReady = 1'b0;
      offer(SUB, 32'h30);
      tick();
      offer(ADDI, 32'h34);
      flush = 1'b1;
      settle();
      checkVal("t5_held_valid", 64'(outValid), 64'd1);
      checkVal("t5_flush_in_ready", 64'(inReady), 64'd0);
      tick();
      flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
      settle();
      checkVal("t5_flushed_valid", 64'(outValid), 64'd0);
      tick();
      settle();
      checkVal("t5_dropped_valid", 64'(outValid), 64'd0);

      // reset during a load-use bubble
      tick();
      offer(LW, 32'h40);
      tick();
      inValid = 1'b0;
      tick();
      offer(ADD_DEP, 32'h44);
      settle();
      checkVal("t5_pre_reset_in_ready", 64'(inReady), 64'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      settle();
      checkVal("t5_post_reset_valid", 64'(outValid), 64'd0);
      checkVal("t5_post_reset_in_ready", 64'(inReady), 64'd1);
      tick();
      inValid = 1'b0;
      settle();
      checkVal("t5_post_reset_rs1", 64'(outRs1), 64'd5);
      tick();

      // lui x7,0x80000 on both widths
      offer(LUI, 32'h50);
      tick();
      inValid = 1'b0;
      settle();
      checkVal("t6_64_valid", 64'(outValid64), 64'd1);
      checkVal("t6_64_in_ready", 64'(inReady64), 64'd1);
      checkVal("t6_64_imm", outImm64, 64'hFFFFFFFF80000000);
      checkVal("t6_64_alu_op", 64'(outAluOp64), 64'd14);
      checkVal("t6_64_pc", outPc64, 64'h50);
      checkVal("t6_64_rd", 64'(outRd64), 64'd7);
      checkVal("t6_64_rs1", 64'(outRs164), 64'd0);
      checkVal("t6_64_rs2", 64'(outRs264), 64'd0);
      checkVal("t6_64_src_a_pc", 64'(outSrcAPc64), 64'd0);
      checkVal("t6_64_src_b_imm", 64'(outSrcBImm64), 64'd1);
      checkVal("t6_64_reg_write", 64'(outRegWrite64), 64'd1);
      checkVal("t6_64_mem_read", 64'(outMemRead64), 64'd0);
      checkVal("t6_64_mem_write", 64'(outMemWrite64), 64'd0);
      checkVal("t6_64_mem_size", 64'(outMemSize64), 64'd0);
      checkVal("t6_64_branch", 64'(outBranch64), 64'd0);
      checkVal("t6_64_jump", 64'(outJump64), 64'd0);
      checkVal("t6_64_illegal", 64'(outIllegal64), 64'd0);
      checkVal("t6_32_imm", 64'(outImm), 64'h80000000);
      checkVal("t6_32_alu_op", 64'(outAluOp), 64'd14);
      tick();
      settle();
      checkVal("t6_drained", 64'(outValid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
